// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding and nibble/word geometry.
// Optional build feature in prog_loader: PROG_LOADER_CHKSUM_EN (adds the VERIFY pass).
package prog_loader_pkg;
    localparam int NIB_W  = 4;
    localparam int DEF_DW = 16;
    localparam int DEF_AW = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        VERIFY  = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/prog_loader_nib_assembler.sv
// Packs a nibble stream, MSB nibble first, into one word; word_ready flags the final nibble.
module nib_assembler
    import prog_loader_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int NIB_PER_WORD = DEF_DW / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [NIB_W-1:0] nib_data,
    output logic [DW-1:0]    word,
    output logic             word_ready
);
    localparam int CW = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;

    logic [CW-1:0] cnt;
    logic [DW-1:0] sr;

    assign word_ready = shift_en && (cnt == CW'(NIB_PER_WORD - 1));
    assign word       = sr;

    // clr only rewinds the nibble count; the last assembled word stays visible on word
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= {sr[DW-NIB_W-1:0], nib_data};
            cnt <= word_ready ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Program BRAM loader: nibble stream -> words written at auto-incrementing addresses, core held meanwhile.
// Define PROG_LOADER_CHKSUM_EN to add a read-back checksum VERIFY pass before DONE.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int AW           = DEF_AW,
    parameter int NIB_PER_WORD = DEF_DW / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             load_end,
    input  logic             nib_valid,
    input  logic [NIB_W-1:0] nib_data,
    output logic             bram_wr,
    output logic [AW-1:0]    bram_addr,
    output logic [DW-1:0]    bram_din,
    input  logic [DW-1:0]    bram_dout,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      word_count,
    output logic             overflow,
    output logic             chk_err
);
    state_t          state, state_nx;
    logic [AW-1:0]   addr;
    logic [AW:0]     wcnt;
    logic            ovf;
    logic            active, shift_en, word_ready, at_top, verify_done;
    logic [DW-1:0]   word;

    assign active   = (state == COLLECT) || (state == WRITE);
    assign shift_en = active && nib_valid && !load_end;
    assign at_top   = (addr == {AW{1'b1}});

    nib_assembler #(.DW(DW), .NIB_PER_WORD(NIB_PER_WORD)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (!active),
        .shift_en   (shift_en),
        .nib_data   (nib_data),
        .word       (word),
        .word_ready (word_ready)
    );

`ifdef PROG_LOADER_CHKSUM_EN
    localparam state_t END_ST = VERIFY;
    logic [DW-1:0] wsum, rsum;
    logic [AW:0]   vcnt;
    logic          rd_p1, chk_q, enter_verify, vrd_issue;

    assign enter_verify = (state_nx == VERIFY) && (state != VERIFY);
    assign vrd_issue    = (state == VERIFY) && (vcnt != wcnt);
    assign verify_done  = (state == VERIFY) && (vcnt == wcnt) && !rd_p1;
    assign chk_err      = chk_q;

    // read-back: address issued in one cycle, data summed on the next
    always_ff @(posedge clk) begin
        if (rst) begin
            wsum  <= '0;
            rsum  <= '0;
            vcnt  <= '0;
            rd_p1 <= 1'b0;
            chk_q <= 1'b0;
        end else begin
            if (state == IDLE && load_start) begin
                wsum  <= '0;
                chk_q <= 1'b0;
            end
            if (state == WRITE)
                wsum <= wsum + word;
            if (enter_verify) begin
                vcnt  <= '0;
                rsum  <= '0;
                rd_p1 <= 1'b0;
            end else if (state == VERIFY) begin
                rd_p1 <= vrd_issue;
                if (vrd_issue)
                    vcnt <= vcnt + 1'b1;
                if (rd_p1)
                    rsum <= rsum + bram_dout;
                if (verify_done)
                    chk_q <= (rsum != wsum);
            end
        end
    end
`else
    localparam state_t END_ST = DONE;
    logic unused_dout;
    assign unused_dout = ^bram_dout;
    assign verify_done = 1'b1;
    assign chk_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_start) state_nx = COLLECT;
            COLLECT: if (load_end) state_nx = END_ST;
                     else if (word_ready) state_nx = WRITE;
            WRITE:   state_nx = (load_end || at_top) ? END_ST : COLLECT;
            VERIFY:  if (verify_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bram_wr  = (state == WRITE);
        cpu_hold = (state != IDLE);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    // the address never wraps: a write at the top address ends the session instead
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            wcnt <= '0;
            ovf  <= 1'b0;
        end else begin
            if (state == IDLE && load_start) begin
                addr <= '0;
                wcnt <= '0;
                ovf  <= 1'b0;
            end
            if (state == WRITE) begin
                wcnt <= wcnt + 1'b1;
                if (at_top)
                    ovf <= 1'b1;
                else
                    addr <= addr + 1'b1;
            end
`ifdef PROG_LOADER_CHKSUM_EN
            if (vrd_issue)
                addr <= addr + 1'b1;
            if (enter_verify)
                addr <= '0;
`endif
        end
    end

    assign bram_addr  = addr;
    assign bram_din   = word;
    assign word_count = wcnt;
    assign overflow   = ovf;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: session-level reference model plus a BRAM model with read-back.
module tb_prog_loader;
    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int MAXW = 1 << AW;

    logic          clk, rst, load_start, load_end, nib_valid;
    logic [3:0]    nib_data;
    logic          bram_wr, cpu_hold, busy, done, overflow, chk_err;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;
    logic [AW:0]   word_count;

    prog_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .nib_valid(nib_valid), .nib_data(nib_data), .bram_wr(bram_wr),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_count(word_count),
        .overflow(overflow), .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    logic [3:0] fixed[$];
    logic [15:0] mem [0:MAXW-1];
    bit         corrupt;
    int         cyc = 0;
    int         ncmp = 0;
    int         nerr = 0;
    int         done_cnt = 0;
    int         wc_d, ovf_d, chk_d, hold_d;

    always @(posedge clk) cyc = cyc + 1;

    // BRAM port-A model: synchronous write, 1-cycle read, optional corruption of word 1 on read
    always @(posedge clk) begin
        if (bram_wr)
            mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr] ^ ((corrupt && bram_addr == 1 && !bram_wr) ? 16'h0001 : 16'h0000);
    end

    always @(negedge clk) begin
        if (bram_wr)
            obs_q.push_back('{int'(bram_addr), int'(bram_din), cyc});
        if (done) begin
            done_cnt++;
            wc_d   = int'(word_count);
            ovf_d  = int'(overflow);
            chk_d  = int'(chk_err);
            hold_d = int'(cpu_hold);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_wr"}, bram_wr, 0);
        check({tag, "_addr"}, bram_addr, 0);
        check({tag, "_din"}, bram_din, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wc"}, word_count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_chk"}, chk_err, 0);
    endtask

    // One load session: n nibbles (from 'fixed' first, then random), optional idle gaps,
    // optional load_end coinciding with the final nibble, optional trailing load_end strobe.
    task automatic run_session(input int n, input int gap_pct, input bit end_with_nib,
                               input bit corrupt_rd, input bit send_end);
        logic [15:0] cur;
        logic [3:0]  nb;
        int          nacc, words, t, exp_chk;
        bit          last_end;
        exp_q.delete();
        obs_q.delete();
        corrupt  = corrupt_rd;
        done_cnt = 0;
        cur = 16'h0;
        nacc = 0;
        words = 0;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("hold_at_start", cpu_hold, 1);
        check("busy_at_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) @(negedge clk);
            nb = (fixed.size() > i) ? fixed[i] : 4'($urandom_range(15));
            last_end = end_with_nib && (i == n - 1);
            nib_valid  = 1'b1;
            nib_data   = nb;
            load_end   = last_end;
            load_start = (i == 5);
            if (!last_end && words < MAXW) begin
                cur = {cur[11:0], nb};
                nacc++;
                if (nacc % 4 == 0) begin
                    exp_q.push_back('{words, int'(cur), cyc + 1});
                    words++;
                end
            end
            @(negedge clk);
            nib_valid  = 1'b0;
            load_end   = 1'b0;
            load_start = 1'b0;
        end
        if (send_end && !(end_with_nib && n > 0)) begin
            load_end = 1'b1;
            @(negedge clk);
            load_end = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
`ifdef PROG_LOADER_CHKSUM_EN
        exp_chk = (corrupt_rd && words >= 2) ? 1 : 0;
`else
        exp_chk = 0;
`endif
        check("done_pulses", done_cnt, 1);
        check("wc_at_done", wc_d, words);
        check("ovf_at_done", ovf_d, (words == MAXW) ? 1 : 0);
        check("chk_at_done", chk_d, exp_chk);
        check("hold_at_done", hold_d, 1);
        check("busy_after", busy, 0);
        check("hold_after", cpu_hold, 0);
        check("wc_after", word_count, words);
        check("n_writes", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("wr_addr", obs_q[i].addr, exp_q[i].addr);
            check("wr_data", obs_q[i].data, exp_q[i].data);
            check("wr_cycle", obs_q[i].cyc, exp_q[i].cyc);
        end
        fixed.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        load_end = 1'b0;
        nib_valid = 1'b0;
        nib_data = 4'h0;
        corrupt = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        fixed = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_session(4, 0, 0, 0, 1);
        check("w1234_size", obs_q.size(), 1);
        check("w1234_data", obs_q[0].data, 32'h1234);
        check("w1234_addr", obs_q[0].addr, 0);

        fixed = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h5, 4'hA, 4'h5, 4'hA};
        run_session(8, 0, 0, 0, 1);
        check("a5_size", obs_q.size(), 2);
        check("a5_data0", obs_q[0].data, 32'hA5A5);
        check("a5_data1", obs_q[1].data, 32'h5A5A);
        check("a5_addr1", obs_q[1].addr, 1);
        check("a5_wc", word_count, 2);

        run_session(6, 0, 0, 0, 1);
        check("six_wc", word_count, 1);

        // reset in the middle of a session
        obs_q.delete();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nib_valid = 1'b1;
            nib_data  = 4'($urandom_range(15));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nib_valid = 1'b0;
        check_reset_outs("rst_mid");
        nib_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nib_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_nowr", obs_q.size(), 0);
        fixed = '{4'h9, 4'h8, 4'h7, 4'h6};
        run_session(4, 0, 0, 0, 1);
        check("post_rst_data", obs_q[0].data, 32'h9876);

        for (int k = 0; k < 12; k++)
            run_session($urandom_range(40), $urandom_range(50), 1'($urandom_range(1)),
                        1'($urandom_range(1)), 1);

        fixed = '{4'hC, 4'h0, 4'hF, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4};
        run_session(8, 0, 0, 1, 1);
        fixed = '{4'hC, 4'h0, 4'hF, 4'hE, 4'h1, 4'h2, 4'h3, 4'h4};
        run_session(8, 0, 0, 0, 1);

        run_session(4 * MAXW + 4, 0, 0, 0, 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_last_addr", obs_q[obs_q.size() - 1].addr, MAXW - 1);

        run_session(4, 0, 0, 0, 1);
        check("ovf_cleared", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
